muldiv_unit: RTL and testbench



---
 rtl/riscv_m_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 43 ++++
 rtl/muldiv_unit.sv | 127 ++++++++++++
 tb/tb_muldiv_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: funct3 op codes, decoder constants and the
// multiply/divide sequencer state encoding.
package riscv_m_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned shift-add multiplier or restoring divider,
// operating on the {hi,lo} accumulator pair.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] next_hi,
  output logic [XLEN-1:0] next_lo
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // The partial remainder always stays below the divisor, so bit XLEN of the
  // trial difference is a reliable borrow flag.
  always_comb begin
    sum     = {1'b0, hi} + {1'b0, operand};
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, operand};
    next_hi = hi;
    next_lo = lo;
    if (is_div) begin
      if (!diff[XLEN]) begin
        next_hi = diff[XLEN-1:0];
        next_lo = {lo[XLEN-2:0], 1'b1};
      end else begin
        next_hi = shifted[XLEN-1:0];
        next_lo = {lo[XLEN-2:0], 1'b0};
      end
    end else if (lo[0]) begin
      next_hi = sum[XLEN:1];
      next_lo = {sum[0], lo[XLEN-1:1]};
    end else begin
      next_hi = {1'b0, hi[XLEN-1:1]};
      next_lo = {hi[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the E stage: runs magnitudes through
// muldiv_step for 32 cycles, then applies the sign fix-up when presenting the result.
module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Start_E,
  input  logic [2:0]      funct3_E,
  input  logic [XLEN-1:0] SrcA_E,
  input  logic [XLEN-1:0] SrcB_E,
  input  logic            Flush_E,
  output logic            StallMD,
  output logic            ResultValid_E,
  output logic [XLEN-1:0] Result_E
);
  import riscv_m_pkg::*;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t state, next_state;

  logic [CNT_WIDTH-1:0] cnt;
  logic [XLEN-1:0]      hi, lo, divisor;
  logic [XLEN-1:0]      step_hi, step_lo;
  logic [2:0]           op;
  logic                 neg_res, neg_rem;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, fast, launch;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, res;

  // Operand decode for the instruction currently sitting in E.
  always_comb begin
    a_signed = (funct3_E == F3_MULH) || (funct3_E == F3_MULHSU) ||
               (funct3_E == F3_DIV)  || (funct3_E == F3_REM);
    b_signed = (funct3_E == F3_MULH) || (funct3_E == F3_DIV) || (funct3_E == F3_REM);
    a_neg    = a_signed & SrcA_E[XLEN-1];
    b_neg    = b_signed & SrcB_E[XLEN-1];
    a_mag    = a_neg ? -SrcA_E : SrcA_E;
    b_mag    = b_neg ? -SrcB_E : SrcB_E;
    div_zero = funct3_E[2] && (SrcB_E == '0);
    div_ovf  = ((funct3_E == F3_DIV) || (funct3_E == F3_REM)) &&
               (SrcA_E == INT_MIN) && (SrcB_E == '1);
    fast     = div_zero | div_ovf;
    launch   = (state == IDLE) && Start_E && !Flush_E;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (launch) next_state = fast ? DONE : CALC;
      CALC:    if (Flush_E) next_state = IDLE;
               else if (cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (op[2]),
    .hi      (hi),
    .lo      (lo),
    .operand (divisor),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  // Fast-path results are loaded pre-signed with both fix-up flags cleared, so
  // DONE can use one output path for every operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      divisor <= '0;
      op      <= F3_MUL;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (launch) begin
      op      <= funct3_E;
      cnt     <= CNT_WIDTH'(XLEN - 1);
      divisor <= b_mag;
      if (fast) begin
        hi      <= div_zero ? SrcA_E : '0;
        lo      <= div_zero ? '1 : INT_MIN;
        neg_res <= 1'b0;
        neg_rem <= 1'b0;
      end else begin
        hi      <= '0;
        lo      <= a_mag;
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
      end
    end else if (state == CALC) begin
      hi  <= step_hi;
      lo  <= step_lo;
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

  always_comb begin
    prod_fix = neg_res ? -{hi, lo} : {hi, lo};
    quot_fix = neg_res ? -lo : lo;
    rem_fix  = neg_rem ? -hi : hi;
    case (op)
      F3_MUL:                        res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               res = quot_fix;
      default:                       res = rem_fix;
    endcase
    ResultValid_E = !rst && !Flush_E && (state == DONE);
    Result_E      = ResultValid_E ? res : '0;
    StallMD       = !rst && !Flush_E &&
                    (((state == IDLE) && Start_E) || (state == CALC));
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, flush/reset/back-to-back
// sequences and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start_E;
  logic [2:0]  funct3_E;
  logic [31:0] SrcA_E, SrcB_E;
  logic        Flush_E;
  logic        StallMD, ResultValid_E;
  logic [31:0] Result_E;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  muldiv_unit dut (
    .clk           (clk),
    .rst           (rst),
    .Start_E       (Start_E),
    .funct3_E      (funct3_E),
    .SrcA_E        (SrcA_E),
    .SrcB_E        (SrcB_E),
    .Flush_E       (Flush_E),
    .StallMD       (StallMD),
    .ResultValid_E (ResultValid_E),
    .Result_E      (Result_E)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: full-width arithmetic on extended operands plus the
  // architectural divide-by-zero and overflow results.
  function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    logic ovf;
    logic [31:0] r;
    ea  = {32'b0, a};
    eb  = {32'b0, b};
    if (f3 == 3'd1 || f3 == 3'd2) ea = {{32{a[31]}}, a};
    if (f3 == 3'd1) eb = {{32{b[31]}}, b};
    p   = ea * eb;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (f3)
      3'd0:          r = p[31:0];
      3'd1, 3'd2, 3'd3: r = p[63:32];
      3'd4:          r = (b == 0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'(sa / sb);
      3'd5:          r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6:          r = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default:       r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int expLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic fastOp;
    fastOp = f3[2] && ((b == 0) ||
             ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF));
    return fastOp ? 1 : 33;
  endfunction

  // Called at posedge+#1; holds Start_E like a stalled E stage and returns at
  // posedge+#1 of the cycle after the result, with Start_E dropped.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output int lat, output int stallBad,
                               output int startCyc);
    int el;
    el       = expLatency(f3, a, b);
    Start_E  = 1'b1;
    funct3_E = f3;
    SrcA_E   = a;
    SrcB_E   = b;
    startCyc = cyc;
    lat      = -1;
    res      = '0;
    stallBad = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (StallMD !== 1'(c < el)) stallBad++;
      if (ResultValid_E === 1'b1) begin
        res = Result_E;
        lat = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    Start_E = 1'b0;
  endtask

  task automatic runAndCheck(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expRes, input int expLat);
    logic [31:0] res;
    int lat, stallBad, sc;
    applyStimulus(f3, a, b, res, lat, stallBad, sc);
    checkOutput({name, "_result"}, res, expRes);
    checkOutput({name, "_latency"}, lat, expLat);
    checkOutput({name, "_stall_errs"}, stallBad, 0);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r1, r2, ra, rb;
    logic [2:0]  rf;
    int l1, l2, s1, s2, sb1, sb2, base;

    vecs.push_back('{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33});
    vecs.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
    vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33});
    vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33});
    vecs.push_back('{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
    vecs.push_back('{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
    vecs.push_back('{3'd5, 32'd100,      32'd7,        32'd14,       33});
    vecs.push_back('{3'd7, 32'd100,      32'd7,        32'd2,        33});
    vecs.push_back('{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{3'd6, 32'd5,        32'd0,        32'd5,        1});
    vecs.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
    vecs.push_back('{3'd3, 32'h00010000, 32'h00010000, 32'h00000001, 33});
    vecs.push_back('{3'd4, 32'h00000009, 32'hFFFFFFFE, 32'hFFFFFFFC, 33});

    rst      = 1'b1;
    Start_E  = 1'b0;
    Flush_E  = 1'b0;
    funct3_E = 3'd0;
    SrcA_E   = '0;
    SrcB_E   = '0;
    repeat (3) @(posedge clk);
    #1;
    Start_E = 1'b1;
    @(negedge clk);
    checkOutput("reset_stall_gated", StallMD, 1'b0);
    checkOutput("reset_valid", ResultValid_E, 1'b0);
    checkOutput("reset_result", Result_E, 32'h0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    Start_E = 1'b0;
    @(negedge clk);
    checkOutput("idle_stall", StallMD, 1'b0);
    @(posedge clk);
    #1;

    foreach (vecs[i])
      runAndCheck($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    @(negedge clk);
    checkOutput("valid_single_strobe", ResultValid_E, 1'b0);
    @(posedge clk);
    #1;

    // Back-to-back multiplies with zero idle cycles between them.
    base = cyc;
    applyStimulus(3'd0, 32'd12345, 32'd678, r1, l1, sb1, s1);
    applyStimulus(3'd0, 32'hDEADBEEF, 32'h10, r2, l2, sb2, s2);
    checkOutput("b2b_first_result", r1, refModel(3'd0, 32'd12345, 32'd678));
    checkOutput("b2b_second_result", r2, refModel(3'd0, 32'hDEADBEEF, 32'h10));
    checkOutput("b2b_first_valid_cycle", s1 + l1 - base, 33);
    checkOutput("b2b_second_valid_cycle", s2 + l2 - base, 67);
    checkOutput("b2b_stall_errs", sb1 + sb2, 0);

    // Flush in CALC cycle 10 aborts the divide.
    Start_E  = 1'b1;
    funct3_E = 3'd5;
    SrcA_E   = 32'd1000;
    SrcB_E   = 32'd3;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    Flush_E = 1'b1;
    @(negedge clk);
    checkOutput("flush_stall_low", StallMD, 1'b0);
    checkOutput("flush_no_valid", ResultValid_E, 1'b0);
    @(posedge clk);
    #1;
    Flush_E = 1'b0;
    Start_E = 1'b0;
    @(negedge clk);
    checkOutput("after_flush_idle_stall", StallMD, 1'b0);
    checkOutput("after_flush_no_valid", ResultValid_E, 1'b0);
    @(posedge clk);
    #1;
    runAndCheck("post_flush_divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);

    // Reset in CALC cycle 20 discards the partial product.
    Start_E  = 1'b1;
    funct3_E = 3'd0;
    SrcA_E   = 32'h12345678;
    SrcB_E   = 32'h9ABCDEF0;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    rst     = 1'b1;
    Start_E = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_stall", StallMD, 1'b0);
    checkOutput("midreset_valid", ResultValid_E, 1'b0);
    checkOutput("midreset_result", Result_E, 32'h0);
    @(posedge clk);
    #1;
    runAndCheck("post_reset_mulhu", 3'd3, 32'h12345678, 32'h9ABCDEF0,
                refModel(3'd3, 32'h12345678, 32'h9ABCDEF0), 33);

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pickOperand();
      rb = pickOperand();
      runAndCheck($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, refModel(rf, ra, rb),
                  expLatency(rf, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
